conv_window_addr_gen: RTL
=========================

Name: conv_window_addr_gen

Overview:
- Generates image-memory read addresses for 2-D sliding-window convolution over an IMG_W x IMG_H frame.
- Kernel size k and stride are set at run time.
- Emits one tap address per beat over a valid/ready handshake, in row-major order within each window and window-major order across the frame.
- Supplies the matching result-memory address with the last tap of each window.
- Sits between the convolution controller and the image/result RAMs.

Parameters:
- IMG_W, 220: image width in pixels (row pitch).
- IMG_H, 220: image height in pixels.
- AW, 16: address width for image and result memories.
- KW, 4: width of the k_size field; maximum kernel size is 2^KW-1.
- SW, 3: width of the stride field.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rstn, input, 1: reset, synchronous, active-low.
- start, input, 1: begin a frame; sampled only in IDLE.
- k_size, input, KW: kernel size k; latched on start.
- stride, input, SW: window step s; latched on start.
- img_base, input, AW: image base address; latched on start.
- res_base, input, AW: result base address; latched on start.
- addr_valid, output, 1: img_addr/tap outputs are valid.
- addr_ready, input, 1: consumer accepts the current beat.
- img_addr, output, AW: current tap address.
- tap_idx, output, 2*KW: tap index ky*k+kx within the current window.
- tap_last, output, 1: current beat is the final tap of the window.
- res_addr, output, AW: result address of the current window; meaningful when tap_last=1.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse at frame end.
- cfg_err, output, 1: one-cycle pulse on rejected configuration.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - FSM goes to IDLE; all counters clear.
  - addr_valid, tap_last, busy, done, cfg_err = 0; img_addr, res_addr, tap_idx = 0.
  - Reset during RUN abandons the frame silently; no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches the configuration.
  - Invalid config (k=0, s=0, k>IMG_W, or k>IMG_H): cfg_err pulses next cycle and the FSM stays in IDLE.
  - Otherwise enter RUN; addr_valid rises the cycle after start (latency 1).
- Derived output grid: OW=(IMG_W-k)/s+1, OH=(IMG_H-k)/s+1, integer floor. Windows wx in 0..OW-1, wy in 0..OH-1; taps kx, ky in 0..k-1.
- Address equations:
  - img_addr = img_base + (wy*s+ky)*IMG_W + wx*s + kx.
  - res_addr = res_base + wy*OW + wx.
  - All arithmetic is modulo 2^AW and wraps silently.
  - Row terms are formed incrementally (add IMG_W per row); no runtime multiplier.
- RUN handshake:
  - A beat transfers on addr_valid&&addr_ready.
  - While addr_ready=0, all outputs hold stable.
  - There are no bubbles: on transfer the next tap is presented the following cycle.
- Counter advance per transfer:
  - kx increments. At kx=k-1: kx=0 and ky increments.
  - At ky=k-1 (tap_last): ky=0 and wx increments.
  - At wx=OW-1: wx=0 and wy increments.
- Frame end:
  - Transfer of tap_last at wx=OW-1, wy=OH-1 enters FIN. addr_valid drops the next cycle.
  - FIN lasts one cycle: done=1, busy=0, then back to IDLE.
  - start in FIN or RUN is ignored.
- tap_last = (kx=k-1 && ky=k-1). For k=1, every beat is tap_last.

Optional Feature:
- Macro: CONV_ADDR_PAD_EN.
- With the macro defined:
  - Adds input pad (KW-1 bits, latched on start) and output tap_pad (1 bit).
  - The grid is computed on the padded frame: OW=(IMG_W+2p-k)/s+1, OH likewise.
  - Tap coordinates are x=wx*s+kx-p, y=wy*s+ky-p.
  - When x or y falls outside the image: tap_pad=1 and img_addr=0. Otherwise tap_pad=0 and normal addressing applies.
  - The invalid-config check uses k>IMG_W+2p and k>IMG_H+2p.
- Without the macro: the port and logic are absent and p is fixed at 0.

Test Plan:
- IMG_W=IMG_H=5, k=3, s=1, bases 0, addr_ready=1:
  - First window: 0,1,2,5,6,7,10,11,12, with tap_last on the 9th beat and res_addr=0.
  - Second window starts at 1.
  - 81 beats total, then done pulses once.
- Same frame, s=2: 4 windows. Window (wx=1, wy=0) starts at 2 with res_addr=1; window (0,1) starts at 10 with res_addr=2; done after 36 beats.
- Backpressure: drop addr_ready for 3 cycles at tap 4 of window 0. img_addr stays 6 and tap_idx stays 4 throughout; the sequence resumes with no skipped or duplicated taps.
- Config error: start with k=0, then with s=0. Each gives one cfg_err pulse; addr_valid and busy never assert.
- Reset mid-frame: deassert rstn during window 2, then restart with k=3, s=1. The first address is img_base; no done pulse from the aborted frame.
- With CONV_ADDR_PAD_EN, 5x5 frame, k=3, s=1, p=1:
  - OW=OH=5.
  - Window 0: taps 0-3 and 6 have tap_pad=1; tap 4 gives addr 0; tap 8 gives addr 6.
  - 225 beats total.

Source files
------------

// File: rtl/conv_window_addr_gen_if.sv
// Tap-address beat bus between conv_window_addr_gen (master) and the image-RAM read port (slave).
// tap_pad exists only when CONV_ADDR_PAD_EN is defined.
interface conv_window_addr_gen_if #(
    parameter int AW = 16,
    parameter int KW = 4
) ();
    // A beat transfers on a cycle where addr_valid && addr_ready at the rising
    // edge; while addr_valid=1 and addr_ready=0 every beat field holds stable.
    logic              addr_valid;
    logic              addr_ready;
    logic [AW-1:0]     img_addr;
    logic [2*KW-1:0]   tap_idx;
    logic              tap_last;
    logic [AW-1:0]     res_addr;
`ifdef CONV_ADDR_PAD_EN
    logic              tap_pad;

    modport master (
        output addr_valid, img_addr, tap_idx, tap_last, res_addr, tap_pad,
        input  addr_ready
    );
    modport slave (
        input  addr_valid, img_addr, tap_idx, tap_last, res_addr, tap_pad,
        output addr_ready
    );
`else
    modport master (
        output addr_valid, img_addr, tap_idx, tap_last, res_addr,
        input  addr_ready
    );
    modport slave (
        input  addr_valid, img_addr, tap_idx, tap_last, res_addr,
        output addr_ready
    );
`endif
endinterface

// File: rtl/conv_window_addr_gen.sv
// Sliding-window tap / result address generator for 2-D convolution over an IMG_W x IMG_H frame.
// Optional zero padding (pad input, tap_pad output) is compiled in with CONV_ADDR_PAD_EN.
module conv_window_addr_gen #(
    parameter int IMG_W = 220,
    parameter int IMG_H = 220,
    parameter int AW    = 16,
    parameter int KW    = 4,
    parameter int SW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [KW-1:0] k_size,
    input  logic [SW-1:0] stride,
    input  logic [AW-1:0] img_base,
    input  logic [AW-1:0] res_base,
`ifdef CONV_ADDR_PAD_EN
    input  logic [KW-2:0] pad,
`endif
    conv_window_addr_gen_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [1:0]    dbg_state
);

    localparam int CW = 16;
    localparam int TW = 2 * KW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Constant-coefficient multiply by the row pitch, built from shifted adds.
    function automatic logic [AW-1:0] times_pitch(input logic [CW-1:0] n);
        logic [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < CW; i++) begin
            if (n[i]) acc = acc + (AW'(IMG_W) << i);
        end
        return acc;
    endfunction

    logic [KW-1:0] r_k;
    logic [SW-1:0] r_s;
    logic [AW-1:0] r_s_pitch;
    logic [KW-1:0] r_kx;
    logic [KW-1:0] r_ky;
    logic [TW-1:0] r_tap;
    logic [CW-1:0] r_xw;
    logic [CW-1:0] r_yw;
    logic [AW-1:0] r_win_row_addr;
    logic [AW-1:0] r_win_addr;
    logic [AW-1:0] r_row_addr;
    logic [AW-1:0] r_res;
    logic          r_cfg_err;

    logic [CW-1:0] w_p_in;
    logic [CW-1:0] w_p;
    logic [CW-1:0] w_wp;
    logic [CW-1:0] w_hp;
    logic [CW-1:0] w_k_in;
    logic [AW-1:0] w_pad_off;
    logic          w_cfg_bad;
    logic          w_run;
    logic          w_fire;
    logic          w_last_kx;
    logic          w_last_ky;
    logic          w_last_wx;
    logic          w_last_wy;
    logic          w_tap_last;
    logic          w_frame_end;
    logic          w_is_pad;

`ifdef CONV_ADDR_PAD_EN
    logic [KW-2:0] r_pad;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;

    assign w_p_in = CW'(pad);
    assign w_p    = CW'(r_pad);
    // Coordinates are kept in padded-frame terms, so the real pixel is (x-p, y-p).
    assign w_x    = r_xw + CW'(r_kx);
    assign w_y    = r_yw + CW'(r_ky);
    assign w_is_pad = (w_x < w_p) || (w_x >= CW'(IMG_W) + w_p) ||
                      (w_y < w_p) || (w_y >= CW'(IMG_H) + w_p);
    assign bus.tap_pad = w_run && w_is_pad;
`else
    assign w_p_in   = '0;
    assign w_p      = '0;
    assign w_is_pad = 1'b0;
`endif

    assign w_wp      = CW'(IMG_W) + (w_p << 1);
    assign w_hp      = CW'(IMG_H) + (w_p << 1);
    assign w_k_in    = CW'(k_size);
    // Origin of the padded frame sits p rows up and p pixels left of img_base.
    assign w_pad_off = times_pitch(w_p_in) + AW'(w_p_in);
    assign w_cfg_bad = (k_size == '0) || (stride == '0) ||
                       (w_k_in > CW'(IMG_W) + (w_p_in << 1)) ||
                       (w_k_in > CW'(IMG_H) + (w_p_in << 1));

    assign w_run       = (r_state == S_RUN);
    assign w_fire      = w_run && bus.addr_ready;
    assign w_last_kx   = (r_kx == r_k - KW'(1));
    assign w_last_ky   = (r_ky == r_k - KW'(1));
    // A window is the last of its row/column when the next step would overrun the frame.
    assign w_last_wx   = (r_xw + CW'(r_s) + CW'(r_k)) > w_wp;
    assign w_last_wy   = (r_yw + CW'(r_s) + CW'(r_k)) > w_hp;
    assign w_tap_last  = w_last_kx && w_last_ky;
    assign w_frame_end = w_tap_last && w_last_wx && w_last_wy;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !w_cfg_bad) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_fire && w_frame_end) w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_k            <= '0;
            r_s            <= '0;
            r_s_pitch      <= '0;
            r_kx           <= '0;
            r_ky           <= '0;
            r_tap          <= '0;
            r_xw           <= '0;
            r_yw           <= '0;
            r_win_row_addr <= '0;
            r_win_addr     <= '0;
            r_row_addr     <= '0;
            r_res          <= '0;
            r_cfg_err      <= 1'b0;
`ifdef CONV_ADDR_PAD_EN
            r_pad          <= '0;
`endif
        end else begin
            r_cfg_err <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_k            <= k_size;
                r_s            <= stride;
                r_s_pitch      <= times_pitch(CW'(stride));
                r_kx           <= '0;
                r_ky           <= '0;
                r_tap          <= '0;
                r_xw           <= '0;
                r_yw           <= '0;
                r_win_row_addr <= img_base - w_pad_off;
                r_win_addr     <= img_base - w_pad_off;
                r_row_addr     <= img_base - w_pad_off;
                r_res          <= res_base;
                r_cfg_err      <= w_cfg_bad;
`ifdef CONV_ADDR_PAD_EN
                r_pad          <= pad;
`endif
            end else if (w_fire) begin
                if (!w_last_kx) begin
                    r_kx  <= r_kx + KW'(1);
                    r_tap <= r_tap + TW'(1);
                end else if (!w_last_ky) begin
                    r_kx       <= '0;
                    r_ky       <= r_ky + KW'(1);
                    r_tap      <= r_tap + TW'(1);
                    r_row_addr <= r_row_addr + AW'(IMG_W);
                end else begin
                    r_kx  <= '0;
                    r_ky  <= '0;
                    r_tap <= '0;
                    r_res <= r_res + AW'(1);
                    if (!w_last_wx) begin
                        r_xw       <= r_xw + CW'(r_s);
                        r_win_addr <= r_win_addr + AW'(r_s);
                        r_row_addr <= r_win_addr + AW'(r_s);
                    end else begin
                        r_xw           <= '0;
                        r_yw           <= r_yw + CW'(r_s);
                        r_win_row_addr <= r_win_row_addr + r_s_pitch;
                        r_win_addr     <= r_win_row_addr + r_s_pitch;
                        r_row_addr     <= r_win_row_addr + r_s_pitch;
                    end
                end
            end
        end
    end

    assign bus.addr_valid = w_run;
    assign bus.img_addr   = (w_run && !w_is_pad) ? (r_row_addr + AW'(r_kx)) : '0;
    assign bus.tap_idx    = w_run ? r_tap : '0;
    assign bus.tap_last   = w_run && w_tap_last;
    assign bus.res_addr   = w_run ? r_res : '0;
    assign cfg_err        = r_cfg_err;
    assign dbg_state      = r_state;

endmodule
